// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and small helpers.
// The bench imports this package so that both sides decode state values identically.
package counter_sequencer_pkg;

    localparam int SEQ_STATE_W = 2;

    // Encodings are fixed so that raw state values in waveforms match the documentation.
    typedef enum logic [SEQ_STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        GAP   = 2'd3
    } seq_state_t;

    // A burst is in progress in every state except IDLE.
    function automatic logic state_is_busy(input seq_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/counter_sequencer_sync_edge_detect.sv
// Synchroniser for an asynchronous level input followed by a rising-edge pulse.
// Reusable for any board-level input such as buttons.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Shift the raw input through the synchroniser chain; the last stage is the safe level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    // The pulse is combinational from flops so the consumer sees it one edge after the
    // synchronised level rises; the consumer registers everything it drives out.
    assign rise = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/counter_sequencer.sv
// Upstream control stage for the counter block: converts a trigger edge into a burst of
// RUN_COUNT counter runs separated by GAP_CYCLES idle cycles, with watchdog and abort.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int RUN_W          = 8,
    parameter int RUN_COUNT      = 4,
    parameter int GAP_W          = 16,
    parameter int GAP_CYCLES     = 16,
    parameter int TMO_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             trigger,
    input  logic             abort,
    input  logic             counter_done,
    input  logic             counter_enabled,
    output logic             counter_start,
    output logic             busy,
    output logic [RUN_W-1:0] run_index,
    output logic             all_done,
    output logic             timeout
);

    // Elaboration-time guards on parameter ranges that the logic below relies on.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("counter_sequencer: SYNC_STAGES must be 2 or more");
    end
    if (RUN_COUNT < 1 || RUN_COUNT > (2 ** RUN_W)) begin : g_bad_run_count
        $error("counter_sequencer: RUN_COUNT must be in 1..2^RUN_W");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("counter_sequencer: TIMEOUT_CYCLES must be 1 or more");
    end

    // Index of the final run of a burst.
    localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUN_COUNT - 1);
    // Gap counter is loaded with GAP_CYCLES-1 and counts down to zero, giving exactly
    // GAP_CYCLES cycles in GAP.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    // Watchdog fires on the TIMEOUT_CYCLES-th cycle spent in RUN.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state_reg, state_next;
    logic [RUN_W-1:0] run_index_reg, run_index_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [TMO_W-1:0] wdog_reg, wdog_next;
    logic             timeout_reg, timeout_next;
    logic             all_done_reg, all_done_next;
    logic             counter_start_reg;
    logic             busy_reg;
    logic             trig_rise;

    sync_edge_detect #(
        .STAGES   (SYNC_STAGES)
    ) u_trigger_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (trigger),
        .rise     (trig_rise)
    );

    // Next-state and next-value logic; priority is abort, then done, then watchdog, then trigger.
    always_comb begin
        state_next     = state_reg;
        run_index_next = run_index_reg;
        gap_next       = gap_reg;
        wdog_next      = wdog_reg;
        timeout_next   = timeout_reg;
        all_done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Abort is ignored here; trigger edges start a fresh burst.
                if (trig_rise) begin
                    state_next     = START;
                    run_index_next = '0;
                    timeout_next   = 1'b0;
                end
            end

            START: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    state_next = RUN;
                    wdog_next  = '0;
                end
            end

            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (counter_done) begin
                    if (run_index_reg == LAST_RUN) begin
                        state_next    = IDLE;
                        all_done_next = 1'b1;
                    end else begin
                        run_index_next = run_index_reg + 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_next = GAP;
                            gap_next   = GAP_LOAD;
                        end else begin
                            state_next = START;
                        end
                    end
                end else if (wdog_reg == TMO_LAST) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end

            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (gap_reg == '0) begin
                    state_next = START;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters and all outputs are registered; outputs are decoded from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            run_index_reg     <= '0;
            gap_reg           <= '0;
            wdog_reg          <= '0;
            timeout_reg       <= 1'b0;
            all_done_reg      <= 1'b0;
            counter_start_reg <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            run_index_reg     <= run_index_next;
            gap_reg           <= gap_next;
            wdog_reg          <= wdog_next;
            timeout_reg       <= timeout_next;
            all_done_reg      <= all_done_next;
            counter_start_reg <= (state_next == START);
            busy_reg          <= state_is_busy(state_next);
        end
    end

    assign counter_start = counter_start_reg;
    assign busy          = busy_reg;
    assign run_index     = run_index_reg;
    assign all_done      = all_done_reg;
    assign timeout       = timeout_reg;

    // START always moves on after one cycle, so start pulses are never adjacent.
    a_no_double_start: assert property (
        @(posedge clock) disable iff (!reset_n) counter_start |=> !counter_start);

    // A done pulse outside RUN has no effect; flag it because it hints at a mis-wired counter.
    a_done_in_run: assert property (
        @(posedge clock) disable iff (!reset_n) counter_done |-> (state_reg == RUN))
        else $warning("counter_sequencer: counter_done outside RUN ignored");

    // A counter that reports done should also report itself busy.
    a_done_when_enabled: assert property (
        @(posedge clock) disable iff (!reset_n) counter_done |-> counter_enabled)
        else $warning("counter_sequencer: counter_done while counter not enabled");

endmodule
